// File: rtl/wheel_state_buffer.sv
// Double-buffered node/velocity state for one soft-body wheel: committed arrays
// stay stable while the body updater streams the next timestep into shadow arrays.
module wheel_state_buffer #(
  parameter int NUM_NODES      = 4,
  parameter int POSITION_SIZE  = 16,
  parameter int VELOCITY_SIZE  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic                                                  init_in,
  input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   init_nodes_in,
  input  logic                                                  step_in,
  output logic                                                  begin_out,
  input  logic signed [POSITION_SIZE-1:0]                       node_in_x,
  input  logic signed [POSITION_SIZE-1:0]                       node_in_y,
  input  logic                                                  node_in_valid,
  input  logic                                                  node_in_done,
  input  logic signed [VELOCITY_SIZE-1:0]                       velocity_in_x,
  input  logic signed [VELOCITY_SIZE-1:0]                       velocity_in_y,
  input  logic                                                  velocity_in_valid,
  input  logic                                                  result_in,
  output logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes_out,
  output logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities_out,
  output logic                                                  busy_out,
  output logic                                                  step_done_out,
  output logic                                                  error_out,
  output logic                                                  overrun_out
);

  localparam int IDX_W  = $clog2(NUM_NODES + 1);
  localparam int ADDR_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] FULL_COUNT = IDX_W'(NUM_NODES);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    NODES,
    VELOCITIES,
    COMMIT
  } state_t;

  state_t state;

  logic [IDX_W-1:0] node_idx;
  logic [IDX_W-1:0] vel_idx;
  logic [CNT_W-1:0] cycle_cnt;

  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] shadow_nodes;
  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] shadow_vels;

  // Counts including a sample arriving in the same cycle as done/result.
  logic [IDX_W-1:0] node_cnt_next;
  logic [IDX_W-1:0] vel_cnt_next;
  logic             timeout_hit;
  logic             node_abort;
  logic             vel_abort;

  always_comb begin
    node_cnt_next = node_in_valid ? node_idx + 1'b1 : node_idx;
    vel_cnt_next  = velocity_in_valid ? vel_idx + 1'b1 : vel_idx;
    timeout_hit   = (cycle_cnt == LAST_CYCLE);
    node_abort    = timeout_hit || velocity_in_valid || result_in ||
                    (node_in_valid && (node_idx == FULL_COUNT)) ||
                    (node_in_done && (node_cnt_next != FULL_COUNT));
    vel_abort     = timeout_hit ||
                    (velocity_in_valid && (vel_idx == FULL_COUNT)) ||
                    (result_in && (vel_cnt_next != FULL_COUNT));
  end

  assign busy_out = (state != IDLE);

  // Any abort returns to IDLE with committed outputs untouched; the shadow
  // contents are simply overwritten by the next accepted step.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      node_idx       <= '0;
      vel_idx        <= '0;
      cycle_cnt      <= '0;
      shadow_nodes   <= '0;
      shadow_vels    <= '0;
      nodes_out      <= '0;
      velocities_out <= '0;
      begin_out      <= 1'b0;
      step_done_out  <= 1'b0;
      error_out      <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      begin_out     <= 1'b0;
      step_done_out <= 1'b0;

      if (step_in && (state != IDLE)) begin
        overrun_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (init_in) begin
            nodes_out      <= init_nodes_in;
            velocities_out <= '0;
            error_out      <= 1'b0;
            overrun_out    <= 1'b0;
          end else if (step_in) begin
            state     <= NODES;
            begin_out <= 1'b1;
            node_idx  <= '0;
            vel_idx   <= '0;
            cycle_cnt <= '0;
          end
        end

        NODES: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (node_abort) begin
            state     <= IDLE;
            error_out <= 1'b1;
          end else begin
            if (node_in_valid) begin
              shadow_nodes[0][node_idx[ADDR_W-1:0]] <= node_in_x;
              shadow_nodes[1][node_idx[ADDR_W-1:0]] <= node_in_y;
              node_idx                              <= node_cnt_next;
            end
            if (node_in_done) begin
              state <= VELOCITIES;
            end
          end
        end

        VELOCITIES: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (vel_abort) begin
            state     <= IDLE;
            error_out <= 1'b1;
          end else begin
            if (velocity_in_valid) begin
              shadow_vels[0][vel_idx[ADDR_W-1:0]] <= velocity_in_x;
              shadow_vels[1][vel_idx[ADDR_W-1:0]] <= velocity_in_y;
              vel_idx                             <= vel_cnt_next;
            end
            if (result_in) begin
              state <= COMMIT;
            end
          end
        end

        COMMIT: begin
          nodes_out      <= shadow_nodes;
          velocities_out <= shadow_vels;
          step_done_out  <= 1'b1;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_state_buffer.sv
// Directed bench for wheel_state_buffer: nominal step, protocol aborts,
// overrun, timeout and asynchronous reset behaviour.
module tb_wheel_state_buffer;

  localparam int N  = 4;
  localparam int PW = 16;
  localparam int VW = 16;
  localparam int TO = 16;

  typedef logic signed [1:0][N-1:0][PW-1:0] pos_arr_t;
  typedef logic signed [1:0][N-1:0][VW-1:0] vel_arr_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 init_in = 1'b0;
  pos_arr_t             init_nodes_in = '0;
  logic                 step_in = 1'b0;
  logic                 begin_out;
  logic signed [PW-1:0] node_in_x = '0;
  logic signed [PW-1:0] node_in_y = '0;
  logic                 node_in_valid = 1'b0;
  logic                 node_in_done = 1'b0;
  logic signed [VW-1:0] velocity_in_x = '0;
  logic signed [VW-1:0] velocity_in_y = '0;
  logic                 velocity_in_valid = 1'b0;
  logic                 result_in = 1'b0;
  pos_arr_t             nodes_out;
  vel_arr_t             velocities_out;
  logic                 busy_out;
  logic                 step_done_out;
  logic                 error_out;
  logic                 overrun_out;

  int checks = 0;
  int failures = 0;
  int begin_total = 0;
  int done_total = 0;

  pos_arr_t init_vals;
  pos_arr_t alt_vals;
  pos_arr_t stream_nodes;
  vel_arr_t stream_vels;
  vel_arr_t zero_vels;
  pos_arr_t zero_nodes;

  wheel_state_buffer #(
    .NUM_NODES      (N),
    .POSITION_SIZE  (PW),
    .VELOCITY_SIZE  (VW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .init_in           (init_in),
    .init_nodes_in     (init_nodes_in),
    .step_in           (step_in),
    .begin_out         (begin_out),
    .node_in_x         (node_in_x),
    .node_in_y         (node_in_y),
    .node_in_valid     (node_in_valid),
    .node_in_done      (node_in_done),
    .velocity_in_x     (velocity_in_x),
    .velocity_in_y     (velocity_in_y),
    .velocity_in_valid (velocity_in_valid),
    .result_in         (result_in),
    .nodes_out         (nodes_out),
    .velocities_out    (velocities_out),
    .busy_out          (busy_out),
    .step_done_out     (step_done_out),
    .error_out         (error_out),
    .overrun_out       (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (begin_out === 1'b1) begin_total++;
    if (step_done_out === 1'b1) done_total++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_init(input pos_arr_t v);
    init_in       = 1'b1;
    init_nodes_in = v;
    tick();
    init_in = 1'b0;
  endtask

  task automatic do_step();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
  endtask

  task automatic send_node(input int i, input logic done);
    node_in_x     = stream_nodes[0][i];
    node_in_y     = stream_nodes[1][i];
    node_in_valid = 1'b1;
    node_in_done  = done;
    tick();
    node_in_valid = 1'b0;
    node_in_done  = 1'b0;
  endtask

  task automatic send_vel(input int i, input logic res);
    velocity_in_x     = stream_vels[0][i];
    velocity_in_y     = stream_vels[1][i];
    velocity_in_valid = 1'b1;
    result_in         = res;
    tick();
    velocity_in_valid = 1'b0;
    result_in         = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #3;
    checks++;
    if (nodes_out !== zero_nodes) begin
      failures++;
      $display("[TB] FAIL reset_nodes got=%h want=%h", nodes_out, zero_nodes);
    end
    checks++;
    if (velocities_out !== zero_vels) begin
      failures++;
      $display("[TB] FAIL reset_vels got=%h want=%h", velocities_out, zero_vels);
    end
    checks++;
    if ({busy_out, begin_out, step_done_out, error_out, overrun_out} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=00000",
               {busy_out, begin_out, step_done_out, error_out, overrun_out});
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_nominal_step();
    int b0;
    int d0;
    do_init(init_vals);
    checks++;
    if (nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL init_nodes got=%h want=%h", nodes_out, init_vals);
    end
    b0 = begin_total;
    d0 = done_total;
    do_step();
    checks++;
    if ({begin_out, busy_out} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL step_accept got=%b want=11", {begin_out, busy_out});
    end
    for (int i = 0; i < N; i++) begin
      send_node(i, (i == N - 1));
      if (i == 0) begin
        checks++;
        if (begin_out !== 1'b0) begin
          failures++;
          $display("[TB] FAIL begin_width got=%b want=0", begin_out);
        end
      end
    end
    checks++;
    if (nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL nodes_held got=%h want=%h", nodes_out, init_vals);
    end
    for (int i = 0; i < N; i++) send_vel(i, 1'b0);
    tick();
    result_in = 1'b1;
    tick();
    result_in = 1'b0;
    checks++;
    if ({busy_out, step_done_out} !== 2'b10 || nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL commit_cycle got=%b/%h want=10/%h",
               {busy_out, step_done_out}, nodes_out, init_vals);
    end
    tick();
    checks++;
    if ({step_done_out, busy_out, error_out} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL step_done got=%b want=100", {step_done_out, busy_out, error_out});
    end
    checks++;
    if (nodes_out !== stream_nodes) begin
      failures++;
      $display("[TB] FAIL commit_nodes got=%h want=%h", nodes_out, stream_nodes);
    end
    checks++;
    if (velocities_out !== stream_vels) begin
      failures++;
      $display("[TB] FAIL commit_vels got=%h want=%h", velocities_out, stream_vels);
    end
    tick();
    checks++;
    if (step_done_out !== 1'b0 || (begin_total - b0) !== 1 || (done_total - d0) !== 1) begin
      failures++;
      $display("[TB] FAIL pulse_counts got=%b/%0d/%0d want=0/1/1",
               step_done_out, begin_total - b0, done_total - d0);
    end
  endtask

  task automatic test_short_node_stream();
    int d0;
    do_init(init_vals);
    d0 = done_total;
    do_step();
    for (int i = 0; i < N - 1; i++) send_node(i, 1'b0);
    node_in_done = 1'b1;
    tick();
    node_in_done = 1'b0;
    checks++;
    if ({error_out, busy_out} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL short_abort got=%b want=10", {error_out, busy_out});
    end
    checks++;
    if (nodes_out !== init_vals || velocities_out !== zero_vels) begin
      failures++;
      $display("[TB] FAIL short_outputs got=%h want=%h", nodes_out, init_vals);
    end
    tick();
    checks++;
    if ((done_total - d0) !== 0) begin
      failures++;
      $display("[TB] FAIL short_no_done got=%0d want=0", done_total - d0);
    end
  endtask

  task automatic test_overrun();
    int b0;
    do_init(init_vals);
    checks++;
    if ({error_out, overrun_out} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL init_clears got=%b want=00", {error_out, overrun_out});
    end
    b0 = begin_total;
    do_step();
    for (int i = 0; i < N; i++) send_node(i, (i == N - 1));
    send_vel(0, 1'b0);
    step_in       = 1'b1;
    init_in       = 1'b1;
    init_nodes_in = alt_vals;
    send_vel(1, 1'b0);
    step_in = 1'b0;
    init_in = 1'b0;
    checks++;
    if ({overrun_out, busy_out} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL overrun_flag got=%b want=11", {overrun_out, busy_out});
    end
    send_vel(2, 1'b0);
    send_vel(3, 1'b1);
    tick();
    checks++;
    if ({step_done_out, error_out} !== 2'b10 || nodes_out !== stream_nodes) begin
      failures++;
      $display("[TB] FAIL overrun_commit got=%b/%h want=10/%h",
               {step_done_out, error_out}, nodes_out, stream_nodes);
    end
    checks++;
    if ((begin_total - b0) !== 1) begin
      failures++;
      $display("[TB] FAIL overrun_begins got=%0d want=1", begin_total - b0);
    end
  endtask

  task automatic test_timeout();
    do_init(init_vals);
    checks++;
    if (overrun_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_cleared got=%b want=0", overrun_out);
    end
    do_step();
    repeat (TO - 1) tick();
    checks++;
    if ({busy_out, error_out} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL pre_timeout got=%b want=10", {busy_out, error_out});
    end
    tick();
    checks++;
    if ({busy_out, error_out} !== 2'b01 || nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL timeout got=%b/%h want=01/%h", {busy_out, error_out}, nodes_out, init_vals);
    end
  endtask

  task automatic test_node_overflow();
    do_init(init_vals);
    do_step();
    for (int i = 0; i < N; i++) send_node(i, 1'b0);
    send_node(0, 1'b0);
    checks++;
    if ({error_out, busy_out} !== 2'b10 || nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL node_overflow got=%b/%h want=10/%h", {error_out, busy_out}, nodes_out, init_vals);
    end
  endtask

  task automatic test_init_priority();
    int b0;
    b0 = begin_total;
    step_in = 1'b1;
    do_init(alt_vals);
    step_in = 1'b0;
    tick();
    checks++;
    if ({busy_out, overrun_out, error_out} !== 3'b000 || (begin_total - b0) !== 0) begin
      failures++;
      $display("[TB] FAIL init_priority got=%b/%0d want=000/0",
               {busy_out, overrun_out, error_out}, begin_total - b0);
    end
    checks++;
    if (nodes_out !== alt_vals) begin
      failures++;
      $display("[TB] FAIL init_alt_nodes got=%h want=%h", nodes_out, alt_vals);
    end
  endtask

  task automatic test_reset_mid_step();
    int d0;
    do_init(init_vals);
    do_step();
    for (int i = 0; i < N; i++) send_node(i, (i == N - 1));
    send_vel(0, 1'b0);
    send_vel(1, 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (nodes_out !== zero_nodes || velocities_out !== zero_vels ||
        {busy_out, begin_out, step_done_out, error_out, overrun_out} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%h/%b want=0/00000", nodes_out,
               {busy_out, begin_out, step_done_out, error_out, overrun_out});
    end
    d0 = done_total;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ((done_total - d0) !== 0 || busy_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset got=%0d/%b want=0/0", done_total - d0, busy_out);
    end
    do_step();
    velocity_in_valid = 1'b1;
    tick();
    velocity_in_valid = 1'b0;
    checks++;
    if ({error_out, busy_out} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL vel_in_nodes got=%b want=10", {error_out, busy_out});
    end
    do_init(init_vals);
    checks++;
    if (error_out !== 1'b0 || nodes_out !== init_vals) begin
      failures++;
      $display("[TB] FAIL init_clears_error got=%b/%h want=0/%h", error_out, nodes_out, init_vals);
    end
  endtask

  initial begin
    zero_nodes = '0;
    zero_vels  = '0;
    for (int i = 0; i < N; i++) begin
      init_vals[0][i]    = 16'(i + 1);
      init_vals[1][i]    = 16'(i + 5);
      alt_vals[0][i]     = 16'(16'h7000 + i);
      alt_vals[1][i]     = 16'(16'h0A00 + i);
      stream_nodes[0][i] = 16'(i * 256 + 9);
      stream_nodes[1][i] = 16'(-(i + 1) * 3);
      stream_vels[0][i]  = 16'(i * 7 - 10);
      stream_vels[1][i]  = 16'(32767 - i);
    end

    test_reset();
    test_nominal_step();
    test_short_node_stream();
    test_overrun();
    test_timeout();
    test_node_overflow();
    test_init_priority();
    test_reset_mid_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
